// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
//
// Target-side responder for the processor memory bus. Every cycle the bus
// address is decoded on addr[15:12] into on-chip RAM, an LED register, six
// seven-segment registers, synchronized board switches and a prescaled
// down-counter timer. Read data is registered and returned on din one cycle
// after the address is presented; writes take effect on the edge where w=1.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous, active-low reset
//   addr[15:0] bus address (already registered by the processor)
//   dout[15:0] write data from the processor
//   w          write strobe
//   din[15:0]  registered read data back to the processor
//   sw[9:0]    asynchronous board switches
//   ledr[9:0]  LED register
//   hex_flat   six 7-bit segment registers, HEXk at [7k+6:7k], active-low
//   timer_irq  timer expired flag
//   bus_err    sticky flag, set by any write to an unmapped address
// -----------------------------------------------------------------------------
module mem_io_responder #(
   parameter int RAM_AW   = 8,
   parameter int PRESCALE = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] addr,
   input  logic [15:0] dout,
   input  logic        w,
   output logic [15:0] din,
   input  logic [9:0]  sw,
   output logic [9:0]  ledr,
   output logic [41:0] hex_flat,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int RAM_DEPTH = 2 ** RAM_AW;
   // A prescaler of 1 still needs a one-bit register so the width is legal.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   localparam logic [3:0] REGION_RAM = 4'h0;
   localparam logic [3:0] REGION_LED = 4'h1;
   localparam logic [3:0] REGION_HEX = 4'h2;
   localparam logic [3:0] REGION_SW  = 4'h3;
   localparam logic [3:0] REGION_TMR = 4'h4;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_LOAD   = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam logic [1:0] TMR_STATUS = 2'd3;

   // ---------------------------------------------------------------- storage
   logic [15:0]   ram_q [RAM_DEPTH];

   logic [15:0]   din_q,     din_d;
   logic [9:0]    ledr_q,    ledr_d;
   logic [41:0]   hex_q,     hex_d;
   logic [9:0]    sw_meta_q;
   logic [9:0]    sw_sync_q;
   logic [1:0]    ctrl_q,    ctrl_d;
   logic [15:0]   load_q,    load_d;
   logic [15:0]   count_q,   count_d;
   logic [PW-1:0] presc_q,   presc_d;
   logic          expired_q, expired_d;
   logic          bus_err_q, bus_err_d;

   // ---------------------------------------------------------------- decode
   logic sel_ram_s;
   logic sel_led_s;
   logic sel_hex_s;
   logic sel_tmr_s;
   logic unmapped_s;

   // Upper RAM-region address bits only alias and are intentionally ignored.
   logic unused_s;
   assign unused_s = ^addr[11:3];

   // Region decode; HEX slots 6 and 7 fall through to unmapped.
   always_comb begin
      sel_ram_s  = 1'b0;
      sel_led_s  = 1'b0;
      sel_hex_s  = 1'b0;
      sel_tmr_s  = 1'b0;
      unmapped_s = 1'b0;
      case (addr[15:12])
         REGION_RAM: sel_ram_s = 1'b1;
         REGION_LED: sel_led_s = 1'b1;
         REGION_HEX: begin
            if (addr[2:0] > 3'd5) begin
               unmapped_s = 1'b1;
            end else begin
               sel_hex_s = 1'b1;
            end
         end
         // SW is read-only; writes are silently ignored and are not errors.
         REGION_SW:  unmapped_s = 1'b0;
         REGION_TMR: sel_tmr_s = 1'b1;
         default:    unmapped_s = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- timer
   logic tmr_run_s;
   logic tick_s;
   logic expire_s;

   assign tmr_run_s = ctrl_q[0] && (count_q != 16'h0000);
   assign tick_s    = tmr_run_s && (presc_q == PRESC_MAX);
   assign expire_s  = tick_s && (count_q == 16'h0001);

   // Timer next-state: prescaler/countdown first, bus writes override after.
   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      presc_d   = presc_q;
      expired_d = expired_q;

      // Prescaler only advances while there is something left to count.
      if (tmr_run_s) begin
         if (tick_s) begin
            presc_d = {PW{1'b0}};
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = presc_q;
      end

      if (tick_s) begin
         if (count_q == 16'h0001) begin
            count_d = ctrl_q[1] ? load_q : 16'h0000;
         end else begin
            count_d = count_q - 16'h0001;
         end
      end else begin
         count_d = count_q;
      end

      if (w && sel_tmr_s) begin
         case (addr[1:0])
            TMR_CTRL:  ctrl_d = dout[1:0];
            TMR_LOAD:  load_d = dout;
            TMR_COUNT: begin
               // A software write beats a tick landing in the same cycle.
               count_d = dout;
               presc_d = {PW{1'b0}};
            end
            TMR_STATUS: begin
               if (dout[0]) begin
                  expired_d = 1'b0;
               end else begin
                  expired_d = expired_q;
               end
            end
            default: ctrl_d = ctrl_q;
         endcase
      end else begin
         ctrl_d = ctrl_q;
      end

      // Expiry is applied last so it wins over a concurrent W1C.
      if (expire_s) begin
         expired_d = 1'b1;
      end else begin
         expired_d = expired_d;
      end
   end

   // ---------------------------------------------------------------- I/O regs
   // LED, HEX and sticky bus-error next-state from bus writes.
   always_comb begin
      ledr_d    = ledr_q;
      hex_d     = hex_q;
      bus_err_d = bus_err_q;

      if (w && sel_led_s) begin
         ledr_d = dout[9:0];
      end else begin
         ledr_d = ledr_q;
      end

      if (w && sel_hex_s) begin
         case (addr[2:0])
            3'd0:    hex_d[6:0]   = dout[6:0];
            3'd1:    hex_d[13:7]  = dout[6:0];
            3'd2:    hex_d[20:14] = dout[6:0];
            3'd3:    hex_d[27:21] = dout[6:0];
            3'd4:    hex_d[34:28] = dout[6:0];
            3'd5:    hex_d[41:35] = dout[6:0];
            default: hex_d        = hex_q;
         endcase
      end else begin
         hex_d = hex_q;
      end

      // Without a valid strobe only write cycles count as real accesses.
      if (w && unmapped_s) begin
         bus_err_d = 1'b1;
      end else begin
         bus_err_d = bus_err_q;
      end
   end

   // ---------------------------------------------------------------- read mux
   // Read data from pre-update state; registered into din below.
   always_comb begin
      din_d = 16'h0000;
      case (addr[15:12])
         REGION_RAM: din_d = ram_q[addr[RAM_AW-1:0]];
         REGION_LED: din_d = {6'b000000, ledr_q};
         REGION_HEX: begin
            case (addr[2:0])
               3'd0:    din_d = {9'b000000000, hex_q[6:0]};
               3'd1:    din_d = {9'b000000000, hex_q[13:7]};
               3'd2:    din_d = {9'b000000000, hex_q[20:14]};
               3'd3:    din_d = {9'b000000000, hex_q[27:21]};
               3'd4:    din_d = {9'b000000000, hex_q[34:28]};
               3'd5:    din_d = {9'b000000000, hex_q[41:35]};
               default: din_d = 16'h0000;
            endcase
         end
         REGION_SW:  din_d = {6'b000000, sw_sync_q};
         REGION_TMR: begin
            case (addr[1:0])
               TMR_CTRL:   din_d = {14'b00000000000000, ctrl_q};
               TMR_LOAD:   din_d = load_q;
               TMR_COUNT:  din_d = count_q;
               TMR_STATUS: din_d = {15'b000000000000000, expired_q};
               default:    din_d = 16'h0000;
            endcase
         end
         default:    din_d = 16'h0000;
      endcase
   end

   // RAM write port; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (w && sel_ram_s) begin
         ram_q[addr[RAM_AW-1:0]] <= dout;
      end
   end

   // All control/status flops with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         din_q     <= 16'h0000;
         ledr_q    <= 10'h000;
         hex_q     <= {42{1'b1}};
         sw_meta_q <= 10'h000;
         sw_sync_q <= 10'h000;
         ctrl_q    <= 2'b00;
         load_q    <= 16'h0000;
         count_q   <= 16'h0000;
         presc_q   <= {PW{1'b0}};
         expired_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         din_q     <= din_d;
         ledr_q    <= ledr_d;
         hex_q     <= hex_d;
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign din       = din_q;
   assign ledr      = ledr_q;
   assign hex_flat  = hex_q;
   assign timer_irq = expired_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_io_responder
//
// Directed testbench. Two responders share one bus: u_dut4 with PRESCALE=4
// and u_dut2 with PRESCALE=2, so both timer scenarios run on one bus.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mem_io_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] addr;
   logic [15:0] dout;
   logic        w;
   logic [9:0]  sw;

   logic [15:0] din4, din2;
   logic [9:0]  ledr4, ledr2;
   logic [41:0] hex4, hex2;
   logic        irq4, irq2;
   logic        berr4, berr2;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [41:0] exp_hex;

   always #5 clk = ~clk;

   mem_io_responder #(.RAM_AW(8), .PRESCALE(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .addr(addr), .dout(dout), .w(w),
      .din(din4), .sw(sw), .ledr(ledr4), .hex_flat(hex4),
      .timer_irq(irq4), .bus_err(berr4)
   );

   mem_io_responder #(.RAM_AW(8), .PRESCALE(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .addr(addr), .dout(dout), .w(w),
      .din(din2), .sw(sw), .ledr(ledr2), .hex_flat(hex2),
      .timer_irq(irq2), .bus_err(berr2)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      addr = a;
      dout = d;
      w    = 1'b1;
      step();
      w    = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      addr = a;
      w    = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0;
      addr    = 16'h0000;
      dout    = 16'h0000;
      w       = 1'b0;
      sw      = 10'h000;
      step();
      step();
      reset_n = 1'b1;

      // Reset state
      check_val("rst_din",  din4,  16'h0000);
      check_val("rst_ledr", ledr4, 10'h000);
      check_val("rst_hex",  hex4,  42'h3FF_FFFF_FFFF);
      check_val("rst_irq",  irq4,  1'b0);
      check_val("rst_berr", berr4, 1'b0);

      // RAM write/read, alias, read-before-write
      wr(16'h0005, 16'h1234);
      rd(16'h0005);
      check_val("ram_rd", din4, 16'h1234);
      rd(16'h0105);
      check_val("ram_alias", din4, 16'h1234);
      wr(16'h0005, 16'hBEEF);
      check_val("ram_rbw_old", din4, 16'h1234);
      rd(16'h0005);
      check_val("ram_rbw_new", din4, 16'hBEEF);

      // LEDR
      wr(16'h1000, 16'h03FF);
      check_val("ledr_wr", ledr4, 10'h3FF);
      rd(16'h1000);
      check_val("ledr_rd", din4, 16'h03FF);

      // HEX
      exp_hex = 42'h3FF_FFFF_FFFF;
      wr(16'h2000, 16'h0005);
      exp_hex[6:0] = 7'h05;
      check_val("hex0_wr", hex4, exp_hex);
      wr(16'h2003, 16'h0000);
      exp_hex[27:21] = 7'h00;
      check_val("hex3_zero", hex4, exp_hex);
      wr(16'h2003, 16'h007F);
      exp_hex[27:21] = 7'h7F;
      check_val("hex3_7f", hex4, exp_hex);
      rd(16'h2000);
      check_val("hex0_rd", din4, 16'h0005);

      // Switch synchronizer: value visible on din 3 edges after sw changes
      sw   = 10'h2A5;
      addr = 16'h3000;
      step();
      check_val("sw_lat1", din4, 16'h0000);
      step();
      check_val("sw_lat2", din4, 16'h0000);
      step();
      check_val("sw_lat3", din4, 16'h02A5);

      // Unmapped handling
      wr(16'h3000, 16'h0001);
      check_val("sw_wr_noerr", berr4, 1'b0);
      rd(16'h2006);
      check_val("unmap_rd_din", din4, 16'h0000);
      check_val("unmap_rd_noerr", berr4, 1'b0);
      wr(16'h9000, 16'h5555);
      check_val("unmap_wr_err", berr4, 1'b1);
      step();
      step();
      check_val("berr_sticky", berr4, 1'b1);
      wr(16'h3000, 16'h0000);
      check_val("berr_sw_wr", berr4, 1'b1);

      // One-shot timer, PRESCALE=4: expiry 12 edges after the CTRL write
      wr(16'h4001, 16'h0003);
      wr(16'h4002, 16'h0003);
      wr(16'h4000, 16'h0001);
      repeat (11) step();
      check_val("os_pre_expire", irq4, 1'b0);
      step();
      check_val("os_expire", irq4, 1'b1);
      rd(16'h4002);
      check_val("os_count_hold", din4, 16'h0000);
      rd(16'h4003);
      check_val("os_status_rd", din4, 16'h0001);
      wr(16'h4003, 16'h0000);
      check_val("os_w0_noclr", irq4, 1'b1);
      wr(16'h4003, 16'h0001);
      check_val("os_w1c", irq4, 1'b0);

      // Autoreload timer, PRESCALE=2: expiries 4 and 8 edges after CTRL write
      wr(16'h4000, 16'h0000);
      check_val("ar_irq_clear", irq2, 1'b0);
      wr(16'h4001, 16'h0002);
      wr(16'h4002, 16'h0002);
      wr(16'h4000, 16'h0003);
      repeat (3) step();
      check_val("ar_pre_expire", irq2, 1'b0);
      step();
      check_val("ar_expire1", irq2, 1'b1);
      rd(16'h4002);
      check_val("ar_reload", din2, 16'h0002);
      wr(16'h4003, 16'h0001);
      check_val("ar_w1c", irq2, 1'b0);
      step();
      check_val("ar_still_clr", irq2, 1'b0);
      wr(16'h4003, 16'h0001);
      check_val("ar_set_wins", irq2, 1'b1);

      // Reset mid-run
      wr(16'h1000, 16'h0155);
      check_val("mid_ledr", ledr4, 10'h155);
      wr(16'h4000, 16'h0001);
      wr(16'h4002, 16'h0005);
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check_val("mr_din",  din4,  16'h0000);
      check_val("mr_ledr", ledr4, 10'h000);
      check_val("mr_hex",  hex4,  42'h3FF_FFFF_FFFF);
      check_val("mr_irq2", irq2,  1'b0);
      check_val("mr_berr", berr4, 1'b0);
      rd(16'h4002);
      check_val("mr_count", din4, 16'h0000);
      rd(16'h4000);
      check_val("mr_ctrl", din4, 16'h0000);
      rd(16'h0005);
      check_val("mr_ram_kept", din4, 16'hBEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
